// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_arb_pkg - shared cmd-word layout, widths and FSM states.  Rev 1.0    |
// +--------------------------------------------------------------------------+
package i2c_arb_pkg;

  localparam int CMD_W  = 12;
  localparam int DATA_W = 9;

  // Command word: {address[6:0], start, read, write, write_multiple, stop}
  localparam int CMD_STOP     = 0;
  localparam int CMD_WMULT    = 1;
  localparam int CMD_WRITE    = 2;
  localparam int CMD_READ     = 3;
  localparam int CMD_START    = 4;
  localparam int CMD_ADDR_LSB = 5;
  localparam int CMD_ADDR_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick - first set request strictly after 'last', modulo NREQ. Rev 1.0  |
// +--------------------------------------------------------------------------+
module rr_pick #(
  parameter int NREQ  = 5,
  parameter int IDX_W = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    w_pos  = last;
    for (int k = 0; k < NREQ; k++) begin
      if (w_pos == IDX_W'(NREQ - 1)) begin
        w_pos = '0;
      end else begin
        w_pos = w_pos + IDX_W'(1);
      end
      if (!any && req[w_pos]) begin
        any           = 1'b1;
        onehot[w_pos] = 1'b1;
        idx           = w_pos;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_bus_arbiter - round-robin owner of one i2c_master per transaction.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ         = 5,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                   clk_50mhz,
  input  logic                   rst_50mhz_n,
  input  logic [NREQ*CMD_W-1:0]  req_cmd,
  input  logic [NREQ-1:0]        req_cmd_valid,
  output logic [NREQ-1:0]        req_cmd_ready,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  input  logic [NREQ-1:0]        req_wdata_valid,
  output logic [NREQ-1:0]        req_wdata_ready,
  output logic [DATA_W-1:0]      req_rdata,
  output logic [NREQ-1:0]        req_rdata_valid,
  input  logic [NREQ-1:0]        req_rdata_ready,
  output logic [CMD_W-1:0]       m_cmd,
  output logic                   m_cmd_valid,
  input  logic                   m_cmd_ready,
  output logic [DATA_W-1:0]      m_wdata,
  output logic                   m_wdata_valid,
  input  logic                   m_wdata_ready,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic                   m_rdata_valid,
  output logic                   m_rdata_ready,
  input  logic                   m_busy,
  output logic [NREQ-1:0]        grant,
  output logic                   timeout_evt
);

  localparam int          c_idx_w      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [10:0] c_hold_limit = 11'(HOLD_TIMEOUT);

  arb_state_t         r_state, w_state_nxt;
  logic [NREQ-1:0]    r_grant, w_grant_nxt;
  logic [c_idx_w-1:0] r_owner, w_owner_nxt;
  logic [c_idx_w-1:0] r_last, w_last_nxt;
  logic [10:0]        r_idle_cnt, w_idle_cnt_nxt;
  logic               r_timeout_evt, w_timeout_nxt;
  logic               r_run;

  logic [NREQ-1:0]    w_pick_onehot;
  logic [c_idx_w-1:0] w_pick_idx;
  logic               w_pick_any;

  logic [CMD_W-1:0]   w_cmd_arr   [NREQ];
  logic [DATA_W-1:0]  w_wdata_arr [NREQ];

  logic w_own, w_route_rd, w_stop_hs, w_owner_active;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_cmd_arr[gi]   = req_cmd[gi*CMD_W +: CMD_W];
    assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (c_idx_w)
  ) u_rr_pick (
    .req    (req_cmd_valid),
    .last   (r_last),
    .onehot (w_pick_onehot),
    .idx    (w_pick_idx),
    .any    (w_pick_any)
  );

  // Payloads are pure muxes on the registered owner; only handshakes are gated.
  assign w_own      = (r_state == ST_OWN);
  assign w_route_rd = (r_state != ST_IDLE);

  assign m_cmd           = w_cmd_arr[r_owner];
  assign m_cmd_valid     = w_own & req_cmd_valid[r_owner];
  assign req_cmd_ready   = w_own ? (r_grant & {NREQ{m_cmd_ready}}) : '0;

  assign m_wdata         = w_wdata_arr[r_owner];
  assign m_wdata_valid   = w_own & req_wdata_valid[r_owner];
  assign req_wdata_ready = w_own ? (r_grant & {NREQ{m_wdata_ready}}) : '0;

  // With no owner, stray read data is swallowed once out of reset.
  assign req_rdata       = m_rdata;
  assign req_rdata_valid = w_route_rd ? (r_grant & {NREQ{m_rdata_valid}}) : '0;
  assign m_rdata_ready   = w_route_rd ? req_rdata_ready[r_owner] : r_run;

  assign grant       = r_grant;
  assign timeout_evt = r_timeout_evt;

  assign w_stop_hs      = m_cmd_valid & m_cmd_ready & m_cmd[CMD_STOP];
  assign w_owner_active = req_cmd_valid[r_owner] | req_wdata_valid[r_owner] | m_busy;

  always_ff @(posedge clk_50mhz) begin
    if (!rst_50mhz_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_last        <= c_idx_w'(NREQ - 1);
      r_idle_cnt    <= '0;
      r_timeout_evt <= 1'b0;
      r_run         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_owner       <= w_owner_nxt;
      r_last        <= w_last_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_timeout_evt <= w_timeout_nxt;
      r_run         <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_idle_cnt_nxt = '0;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ST_OWN;
          w_grant_nxt = w_pick_onehot;
          w_owner_nxt = w_pick_idx;
          w_last_nxt  = w_pick_idx;
        end
      end
      ST_OWN: begin
        if (w_stop_hs) begin
          w_state_nxt = ST_DRAIN;
        end else if (r_idle_cnt == c_hold_limit) begin
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          w_timeout_nxt = 1'b1;
        end else if (!w_owner_active) begin
          w_idle_cnt_nxt = r_idle_cnt + 11'd1;
        end
      end
      ST_DRAIN: begin
        if (!m_busy && !m_rdata_valid) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_bus_arbiter - directed self-checking bench.  Rev 1.0              |
// +--------------------------------------------------------------------------+
module tb_i2c_bus_arbiter;

  localparam int NREQ = 5;

  logic        clk_50mhz;
  logic        rst_50mhz_n;
  logic [59:0] req_cmd;
  logic [4:0]  req_cmd_valid;
  wire  [4:0]  req_cmd_ready;
  logic [44:0] req_wdata;
  logic [4:0]  req_wdata_valid;
  wire  [4:0]  req_wdata_ready;
  wire  [8:0]  req_rdata;
  wire  [4:0]  req_rdata_valid;
  logic [4:0]  req_rdata_ready;
  wire  [11:0] m_cmd;
  wire         m_cmd_valid;
  logic        m_cmd_ready;
  wire  [8:0]  m_wdata;
  wire         m_wdata_valid;
  logic        m_wdata_ready;
  logic [8:0]  m_rdata;
  logic        m_rdata_valid;
  wire         m_rdata_ready;
  logic        m_busy;
  wire  [4:0]  grant;
  wire         timeout_evt;

  int total = 0;
  int bad   = 0;

  i2c_bus_arbiter #(
    .NREQ         (NREQ),
    .HOLD_TIMEOUT (1024)
  ) dut (
    .clk_50mhz       (clk_50mhz),
    .rst_50mhz_n     (rst_50mhz_n),
    .req_cmd         (req_cmd),
    .req_cmd_valid   (req_cmd_valid),
    .req_cmd_ready   (req_cmd_ready),
    .req_wdata       (req_wdata),
    .req_wdata_valid (req_wdata_valid),
    .req_wdata_ready (req_wdata_ready),
    .req_rdata       (req_rdata),
    .req_rdata_valid (req_rdata_valid),
    .req_rdata_ready (req_rdata_ready),
    .m_cmd           (m_cmd),
    .m_cmd_valid     (m_cmd_valid),
    .m_cmd_ready     (m_cmd_ready),
    .m_wdata         (m_wdata),
    .m_wdata_valid   (m_wdata_valid),
    .m_wdata_ready   (m_wdata_ready),
    .m_rdata         (m_rdata),
    .m_rdata_valid   (m_rdata_valid),
    .m_rdata_ready   (m_rdata_ready),
    .m_busy          (m_busy),
    .grant           (grant),
    .timeout_evt     (timeout_evt)
  );

  initial clk_50mhz = 1'b0;
  always #10 clk_50mhz = ~clk_50mhz;

  task automatic cyc();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_50mhz);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Owner i: start+write beat (0xAB4), then stop beat (0xAA1), then release.
  task automatic own_and_stop(input int i, input string tag);
    int n;
    n = 0;
    smp();
    while (grant == 5'd0 && n < 16) begin
      cyc();
      smp();
      n++;
    end
    chk({tag, "_grant"}, grant, 32'(1 << i));
    chk({tag, "_cmd"}, m_cmd, 32'h0AB4);
    cyc();
    req_cmd[12*i +: 12] = 12'hAA1;
    smp();
    chk({tag, "_stop"}, m_cmd, 32'h0AA1);
    cyc();
    req_cmd_valid[i] = 1'b0;
    smp();
    chk({tag, "_drain"}, grant, 32'(1 << i));
    cyc();
    smp();
    chk({tag, "_release"}, grant, 32'h0);
  endtask

  initial begin
    int n;
    rst_50mhz_n     = 1'b0;
    req_cmd         = '0;
    req_cmd_valid   = '0;
    req_wdata       = '0;
    req_wdata_valid = '0;
    req_rdata_ready = '0;
    m_cmd_ready     = 1'b1;
    m_wdata_ready   = 1'b1;
    m_rdata         = '0;
    m_rdata_valid   = 1'b0;
    m_busy          = 1'b0;

    // Reset values
    repeat (3) cyc();
    smp();
    chk("rst_grant", grant, 32'h0);
    chk("rst_tevt", timeout_evt, 32'h0);
    chk("rst_cmd_rdy", req_cmd_ready, 32'h0);
    chk("rst_wd_rdy", req_wdata_ready, 32'h0);
    chk("rst_m_rd_rdy", m_rdata_ready, 32'h0);
    chk("rst_m_cmd_vld", m_cmd_valid, 32'h0);
    chk("rst_m_wd_vld", m_wdata_valid, 32'h0);
    chk("rst_rd_vld", req_rdata_valid, 32'h0);

    // Stray read data in IDLE is discarded
    cyc();
    rst_50mhz_n = 1'b1;
    cyc();
    m_rdata       = 9'h0AB;
    m_rdata_valid = 1'b1;
    smp();
    chk("stray_rdy", m_rdata_ready, 32'h1);
    chk("stray_vld", req_rdata_valid, 32'h0);

    // Single requester 2
    cyc();
    m_rdata_valid    = 1'b0;
    req_cmd[24 +: 12] = 12'hAB4;
    req_cmd_valid[2] = 1'b1;
    m_busy           = 1'b1;
    smp();
    chk("s_grant_t", grant, 32'h0);
    cyc();
    smp();
    chk("s_grant_t1", grant, 32'h04);
    chk("s_m_cmd", m_cmd, 32'h0AB4);
    chk("s_m_cmd_vld", m_cmd_valid, 32'h1);
    chk("s_cmd_rdy", req_cmd_ready, 32'h04);
    cyc();
    req_cmd_valid[2]    = 1'b0;
    req_wdata[18 +: 9]  = 9'h107;
    req_wdata_valid[2]  = 1'b1;
    smp();
    chk("s_m_wdata", m_wdata, 32'h107);
    chk("s_wd_rdy", req_wdata_ready, 32'h04);
    chk("s_m_cmd_idle", m_cmd_valid, 32'h0);
    cyc();
    req_wdata_valid[2] = 1'b0;
    req_cmd[24 +: 12]  = 12'hAA1;
    req_cmd_valid[2]   = 1'b1;
    smp();
    chk("s_m_stop", m_cmd, 32'h0AA1);
    cyc();
    req_cmd_valid[2] = 1'b0;
    m_busy           = 1'b0;
    smp();
    chk("s_drain_grant", grant, 32'h04);
    chk("s_drain_cmd_rdy", req_cmd_ready, 32'h0);
    cyc();
    smp();
    chk("s_idle_grant", grant, 32'h0);

    // Contention after a fresh reset: order 0, 1, 3
    cyc();
    rst_50mhz_n = 1'b0;
    cyc();
    cyc();
    rst_50mhz_n = 1'b1;
    req_cmd[0 +: 12]  = 12'hAB4;
    req_cmd[12 +: 12] = 12'hAB4;
    req_cmd[36 +: 12] = 12'hAB4;
    req_cmd_valid     = 5'b01011;
    own_and_stop(0, "c0");
    own_and_stop(1, "c1");
    own_and_stop(3, "c3");

    // Read routing to requester 1
    cyc();
    req_cmd[12 +: 12] = 12'hA19;
    req_cmd_valid[1]  = 1'b1;
    smp();
    cyc();
    smp();
    chk("r_grant", grant, 32'h02);
    cyc();
    req_cmd_valid[1] = 1'b0;
    m_busy           = 1'b1;
    smp();
    chk("r_drain_grant", grant, 32'h02);
    cyc();
    m_rdata         = 9'h13C;
    m_rdata_valid   = 1'b1;
    req_rdata_ready = 5'b00010;
    smp();
    chk("r_rd_vld", req_rdata_valid, 32'h02);
    chk("r_rdata", req_rdata, 32'h13C);
    chk("r_m_rd_rdy", m_rdata_ready, 32'h1);
    cyc();
    m_rdata_valid = 1'b0;
    smp();
    chk("r_busy_hold", grant, 32'h02);
    cyc();
    m_busy = 1'b0;
    smp();
    chk("r_busy_fall", grant, 32'h02);
    cyc();
    smp();
    chk("r_release", grant, 32'h0);
    req_rdata_ready = '0;

    // Timeout: requester 0 goes idle mid-transaction, 4 waits
    cyc();
    req_cmd[0 +: 12] = 12'hAB4;
    req_cmd_valid[0] = 1'b1;
    cyc();
    smp();
    chk("t_grant0", grant, 32'h01);
    cyc();
    req_cmd_valid[0]  = 1'b0;
    req_cmd[48 +: 12] = 12'hAA1;
    req_cmd_valid[4]  = 1'b1;
    smp();
    chk("t_blocked4", req_cmd_ready, 32'h01);
    n = 0;
    while (!timeout_evt && n < 1100) begin
      cyc();
      smp();
      n++;
    end
    chk("t_cycles", n, 32'd1025);
    chk("t_evt", timeout_evt, 32'h1);
    chk("t_grant_clr", grant, 32'h0);
    cyc();
    smp();
    chk("t_evt_once", timeout_evt, 32'h0);
    chk("t_grant4", grant, 32'h10);
    chk("t_m_cmd4", m_cmd, 32'h0AA1);
    cyc();
    req_cmd_valid[4] = 1'b0;
    smp();
    chk("t_drain4", grant, 32'h10);
    cyc();
    smp();
    chk("t_release4", grant, 32'h0);

    // Non-owner blocking, then reset mid-write
    cyc();
    req_cmd[0 +: 12] = 12'hAB4;
    req_cmd_valid[0] = 1'b1;
    cyc();
    req_cmd[36 +: 12] = 12'hAB4;
    req_cmd_valid[3]  = 1'b1;
    smp();
    chk("b_grant0", grant, 32'h01);
    chk("b_cmd_rdy", req_cmd_ready, 32'h01);
    cyc();
    req_wdata[0 +: 9]  = 9'h1AA;
    req_wdata_valid[0] = 1'b1;
    smp();
    chk("b_m_wd_vld", m_wdata_valid, 32'h1);
    chk("b_m_wdata", m_wdata, 32'h1AA);
    cyc();
    rst_50mhz_n = 1'b0;
    cyc();
    smp();
    chk("mr_grant", grant, 32'h0);
    chk("mr_cmd_rdy", req_cmd_ready, 32'h0);
    chk("mr_wd_rdy", req_wdata_ready, 32'h0);
    chk("mr_m_rd_rdy", m_rdata_ready, 32'h0);
    chk("mr_m_wd_vld", m_wdata_valid, 32'h0);
    chk("mr_m_cmd_vld", m_cmd_valid, 32'h0);
    cyc();
    rst_50mhz_n = 1'b1;
    cyc();
    smp();
    chk("mr_next_grant", grant, 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
